// File: rtl/memory_access_stage.sv
// memory_access_stage
//   MEM pipeline stage. Takes the EX/MEM register contents and performs word
//   loads and stores over a request/acknowledge data-memory port. It holds
//   the upstream pipeline while an access is outstanding and drives the
//   MEM/WB pipeline register that feeds writeback.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     defined   : an access that is not acked within TIMEOUT cycles in REQ
//                 is aborted and MemErrM pulses for one cycle.
//     undefined : REQ waits indefinitely for MemAck and MemErrM is tied to 0.
//
//   Parameters
//     TIMEOUT     maximum cycles spent in REQ before abort (2..255)
//
//   Ports
//     clk, rst                         clock, synchronous active-high reset
//     RegWriteM, ResultSrcM, MemWriteM EX/MEM control (ResultSrcM=1: load)
//     ALUResultM, WriteDataM           effective address / ALU result, store data
//     RdM, PCPlus4M                    destination register, PC+4
//     StallM                           combinational hold for EX/MEM and earlier
//     MemReq, MemWe                    registered request / write strobe
//     MemAddr, MemWData                word-aligned address, store data
//     MemAck, MemRData                 single-cycle ack, load data valid with ack
//     MemErrM                          one-cycle pulse on timeout abort
//     RegWriteW, ResultSrcW, RdW       MEM/WB control
//     ReadDataW, ALUResultW, PCPlus4W  MEM/WB data
module memory_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MemErrM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : gTimeoutRange
    $error("memory_access_stage: TIMEOUT must be in 2..255");
  end

  logic [0:0] stateReg;
  logic [0:0] stateNext;
  logic       acc;
  logic       startAcc;
  logic       ackDone;
  logic       timeoutHit;

  // Bubbles carry ResultSrcM=0 and MemWriteM=0, so they never start an access.
  assign acc      = ResultSrcM | MemWriteM;
  assign startAcc = (stateReg == IDLE) & acc;
  // MemAck only means something while a request is outstanding.
  assign ackDone  = (stateReg == REQ) & MemAck;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] waitCntReg;
  logic       memErrReg;

  // An ack in the same cycle as the limit wins, hence the ~MemAck term.
  assign timeoutHit = (stateReg == REQ) & ~MemAck & (waitCntReg == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCntReg <= '0;
      memErrReg  <= 1'b0;
    end else begin
      memErrReg <= timeoutHit;
      if (startAcc) begin
        waitCntReg <= '0;
      end else if ((stateReg == REQ) && !MemAck) begin
        waitCntReg <= waitCntReg + 8'd1;
      end
    end
  end

  assign MemErrM = memErrReg;
`else
  assign timeoutHit = 1'b0;
  assign MemErrM    = 1'b0;
`endif

  // Stall drops combinationally in the ack (or abort) cycle so the next
  // instruction enters on the following edge.
  assign StallM = startAcc | ((stateReg == REQ) & ~MemAck & ~timeoutHit);

  always_comb begin
    stateNext = stateReg;
    if (startAcc) begin
      stateNext = REQ;
    end else if (ackDone || timeoutHit) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Memory port: captured once on the IDLE detect cycle and held for the
  // whole REQ phase; only MemReq changes when the access ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
    end else if (startAcc) begin
      MemReq   <= 1'b1;
      MemWe    <= MemWriteM;
      MemAddr  <= {ALUResultM[31:2], 2'b00};
      MemWData <= WriteDataM;
    end else if (ackDone || timeoutHit) begin
      MemReq <= 1'b0;
    end
  end

  // MEM/WB register. While stalled only the control bits are cleared, so a
  // stalled instruction can never write back twice; data fields just hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
    end else begin
      // An aborted access must not update the register file.
      RegWriteW  <= RegWriteM & ~timeoutHit;
      ResultSrcW <= ResultSrcM;
      ReadDataW  <= (ackDone && ResultSrcM) ? MemRData : 32'h0;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage
//   Self-checking bench for memory_access_stage. Directed scenarios plus a
//   randomized back-to-back instruction stream whose expected writeback and
//   stall timing come from an instruction-level model of the stage.
module tb_memory_access_stage;

  logic        clk;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM, MemReq, MemWe, MemAck, MemErrM;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic        RegWriteW, ResultSrcW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;

  int checks = 0;
  int errors = 0;

  wire [102:0] wbBus   = {RegWriteW, ResultSrcW, RdW, ALUResultW, PCPlus4W, ReadDataW};
  wire [65:0]  portBus = {MemReq, MemWe, MemAddr, MemWData};

  memory_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .StallM(StallM), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData), .MemErrM(MemErrM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
    .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .RdW(RdW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rw, input logic rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; MemAck = 1'b0; MemRData = 32'h0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({wbBus, portBus, StallM, MemErrM} !== '0) begin
      errors++;
      $display("FAIL reset_state: wb=%h port=%h stall=%b err=%b required all zero",
               wbBus, portBus, StallM, MemErrM);
    end
    rst = 1'b0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_alu_passthrough();
    drive(1, 0, 0, 32'h42, 32'h99, 5'd5, 32'h1000);
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL alu_stall: got %b required 0", StallM);
    end
    @(negedge clk);
    checks++;
    if (wbBus !== {1'b1, 1'b0, 5'd5, 32'h42, 32'h1000, 32'h0}) begin
      errors++; $display("FAIL alu_wb: got %h required %h", wbBus,
                         {1'b1, 1'b0, 5'd5, 32'h42, 32'h1000, 32'h0});
    end
    $display("alu: ALUResultW=%h RdW=%0d", ALUResultW, RdW);
  endtask

  task automatic test_load_immediate_ack();
    drive(1, 1, 0, 32'h103, 32'h77, 5'd7, 32'h2004);
    #1;
    checks++;
    if ({StallM, MemReq} !== 2'b10) begin
      errors++; $display("FAIL load_detect: stall,req=%b required 10", {StallM, MemReq});
    end
    @(negedge clk);
    checks++;
    if (portBus !== {1'b1, 1'b0, 32'h100, 32'h77}) begin
      errors++; $display("FAIL load_port: got %h required %h", portBus,
                         {1'b1, 1'b0, 32'h100, 32'h77});
    end
    MemAck = 1'b1; MemRData = 32'hCAFE_F00D;
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL load_ack_stall: got %b required 0", StallM);
    end
    @(negedge clk);
    MemAck = 1'b0; MemRData = 32'h0;
    checks++;
    if ({wbBus, MemReq} !== {1'b1, 1'b1, 5'd7, 32'h103, 32'h2004, 32'hCAFE_F00D, 1'b0}) begin
      errors++; $display("FAIL load_wb: wb=%h req=%b required wb=%h req=0", wbBus, MemReq,
                         {1'b1, 1'b1, 5'd7, 32'h103, 32'h2004, 32'hCAFE_F00D});
    end
    $display("load: ReadDataW=%h", ReadDataW);
  endtask

  task automatic test_store_delayed_ack();
    drive(0, 0, 1, 32'h20, 32'h1234_5678, 5'd3, 32'h3008);
    @(negedge clk);
    for (int k = 0; k <= 3; k++) begin
      MemAck = (k == 3);
      #1;
      checks++;
      if ({portBus, StallM, RegWriteW} !== {1'b1, 1'b1, 32'h20, 32'h1234_5678, (k != 3), 1'b0}) begin
        errors++;
        $display("FAIL store_req_cycle%0d: port=%h stall=%b rw=%b required port=%h stall=%b rw=0",
                 k, portBus, StallM, RegWriteW, {1'b1, 1'b1, 32'h20, 32'h1234_5678}, (k != 3));
      end
      @(negedge clk);
    end
    MemAck = 1'b0;
    checks++;
    if ({wbBus, MemReq} !== {1'b0, 1'b0, 5'd3, 32'h20, 32'h3008, 32'h0, 1'b0}) begin
      errors++; $display("FAIL store_wb: wb=%h req=%b", wbBus, MemReq);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({MemReq, StallM} !== 2'b00) begin
      errors++; $display("FAIL store_no_dup: req,stall=%b required 00", {MemReq, StallM});
    end
    $display("store: completed with single ack");
  endtask

  task automatic test_reset_mid_access();
    drive(1, 1, 0, 32'h80, 32'h0, 5'd9, 32'h4000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({wbBus, MemReq, MemWe, MemAddr, StallM} !== '0) begin
      errors++; $display("FAIL rst_mid: wb=%h req=%b addr=%h stall=%b required zero",
                         wbBus, MemReq, MemAddr, StallM);
    end
    @(negedge clk);
    MemAck = 1'b1; MemRData = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL rst_late_ack_stall: got %b required 0", StallM);
    end
    @(negedge clk);
    MemAck = 1'b0;
    checks++;
    if ({wbBus, MemReq} !== '0) begin
      errors++; $display("FAIL rst_late_ack: wb=%h req=%b required zero", wbBus, MemReq);
    end
    $display("reset mid-access: late ack ignored");
  endtask

  // Instruction-level model: each instruction either passes in one cycle or
  // occupies one detect cycle plus (delay+1) request cycles, and its
  // writeback is fully determined by its own fields and the returned data.
  task automatic test_random_back_to_back();
    int kind, delay;
    logic rw, rs, mw;
    logic [31:0] alu, wd, pc, rdata;
    logic [4:0] rd;
    logic [102:0] expWb;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      delay = $urandom_range(0, 3);
      rs = (kind == 1); mw = (kind == 2);
      rw = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      alu = $urandom(); wd = $urandom(); pc = $urandom(); rdata = $urandom();
      rd = 5'($urandom_range(0, 31));
      drive(rw, rs, mw, alu, wd, rd, pc);
      MemAck = 1'($urandom_range(0, 1));
      MemRData = $urandom();
      #1;
      checks++;
      if (StallM !== (rs | mw)) begin
        errors++; $display("FAIL rnd%0d_detect_stall: got %b required %b", n, StallM, rs | mw);
      end
      @(negedge clk);
      if (rs | mw) begin
        for (int k = 0; k <= delay; k++) begin
          MemAck = (k == delay);
          MemRData = (k == delay) ? rdata : $urandom();
          #1;
          checks++;
          if ({portBus, StallM, RegWriteW, ResultSrcW} !==
              {1'b1, mw, alu[31:2], 2'b00, wd, (k != delay), 2'b00}) begin
            errors++;
            $display("FAIL rnd%0d_req%0d: port=%h stall=%b rw=%b rs=%b required port=%h stall=%b",
                     n, k, portBus, StallM, RegWriteW, ResultSrcW,
                     {1'b1, mw, alu[31:2], 2'b00, wd}, (k != delay));
          end
          @(negedge clk);
        end
        MemAck = 1'b0;
      end
      expWb = {rw, rs, rd, alu, pc, rs ? rdata : 32'h0};
      checks++;
      if ({wbBus, MemReq, MemErrM} !== {expWb, 2'b00}) begin
        errors++; $display("FAIL rnd%0d_wb: wb=%h req=%b err=%b required wb=%h req=0 err=0",
                           n, wbBus, MemReq, MemErrM, expWb);
      end
      $display("rnd%0d: kind=%0d delay=%0d addr=%h wb=%h", n, kind, delay, alu, wbBus);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    drive(1, 1, 0, 32'h44, 32'h0, 5'd9, 32'h5000);
    MemAck = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if ({StallM, MemErrM} !== {(k < 4), 1'b0}) begin
        errors++; $display("FAIL tmo_cycle%0d: stall,err=%b required %b0", k, {StallM, MemErrM}, (k < 4));
      end
      @(negedge clk);
    end
    checks++;
    if ({MemErrM, MemReq, RegWriteW, ReadDataW} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL tmo_abort: err=%b req=%b rw=%b rd=%h required 1 0 0 0",
                         MemErrM, MemReq, RegWriteW, ReadDataW);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (MemErrM !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse_width: err=%b required 0", MemErrM);
    end
    drive(1, 1, 0, 32'h48, 32'h0, 5'd10, 32'h5004);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      MemAck = (k == 4); MemRData = 32'hBEEF_0004;
      #1;
      checks++;
      if (StallM !== (k < 4)) begin
        errors++; $display("FAIL tmo_ack_cycle%0d: stall=%b required %b", k, StallM, (k < 4));
      end
      @(negedge clk);
    end
    MemAck = 1'b0;
    checks++;
    if ({MemErrM, RegWriteW, ReadDataW} !== {1'b0, 1'b1, 32'hBEEF_0004}) begin
      errors++; $display("FAIL tmo_ack_wins: err=%b rw=%b rd=%h required 0 1 beef0004",
                         MemErrM, RegWriteW, ReadDataW);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (MemErrM !== 1'b0) begin
      errors++; $display("FAIL tmo_ack_no_err: err=%b required 0", MemErrM);
    end
    $display("timeout: abort and ack-wins cases done");
`else
    drive(1, 1, 0, 32'h44, 32'h0, 5'd9, 32'h5000);
    MemAck = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      #1;
      checks++;
      if ({StallM, MemReq, MemErrM} !== 3'b110) begin
        errors++; $display("FAIL wait_cycle%0d: stall,req,err=%b required 110", k, {StallM, MemReq, MemErrM});
      end
      @(negedge clk);
    end
    MemAck = 1'b1; MemRData = 32'h0BAD_CAFE;
    @(negedge clk);
    MemAck = 1'b0;
    checks++;
    if ({MemErrM, RegWriteW, ReadDataW, MemReq} !== {1'b0, 1'b1, 32'h0BAD_CAFE, 1'b0}) begin
      errors++; $display("FAIL long_wait_done: err=%b rw=%b rd=%h req=%b required 0 1 0badcafe 0",
                         MemErrM, RegWriteW, ReadDataW, MemReq);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("long wait: access completed after 20 idle REQ cycles");
`endif
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load_immediate_ack();
    test_store_delayed_ack();
    test_reset_mid_access();
    test_random_back_to_back();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage placed directly downstream of the execute stage. It consumes the EX/MEM register outputs and performs word loads and stores over a request/acknowledge data-memory port. The block stalls the upstream pipeline while an access is outstanding and drives the MEM/WB pipeline register that feeds writeback.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of cycles in REQ before an access is aborted. Used only when MEM_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteM  in  1  register write enable from EX/MEM.
- ResultSrcM  in  1  1 = load instruction.
- MemWriteM  in  1  1 = store instruction.
- ALUResultM  in  32  effective address or ALU result.
- WriteDataM  in  32  store data.
- RdM  in  5  destination register.
- PCPlus4M  in  32  PC+4 of the instruction.
- StallM  out  1  combinational; holds EX/MEM and all earlier stages.
- MemReq  out  1  data-memory request, registered.
- MemWe  out  1  1 = write request.
- MemAddr  out  32  word address, ALUResultM with bits [1:0] forced to 0.
- MemWData  out  32  store data.
- MemAck  in  1  single-cycle completion pulse from memory.
- MemRData  in  32  load data, valid only in the cycle MemAck is high.
- MemErrM  out  1  one-cycle pulse on timeout abort. Tied to 0 when MEM_TIMEOUT_EN is undefined.
- RegWriteW, ResultSrcW  out  1 each  MEM/WB control signals.
- ReadDataW, ALUResultW, PCPlus4W  out  32 each  MEM/WB data.
- RdW  out  5  MEM/WB destination register.

## Operation
- Access condition: `acc = ResultSrcM | MemWriteM`. Bubbles (all-zero EX/MEM contents) never access memory.
- FSM has two states, IDLE and REQ.
  - IDLE with acc=1: go to REQ on the next edge. Latch MemAddr, MemWData and MemWe=MemWriteM, and set MemReq=1.
  - IDLE with acc=0: stay in IDLE. MEM/WB loads the EX/MEM values directly with ReadDataW=0.
  - REQ with MemAck=1: go to IDLE and clear MemReq. MEM/WB loads the EX/MEM values; ReadDataW = MemRData for a load, 0 for a store.
  - REQ with MemAck=0: stay in REQ. MemReq, MemAddr, MemWData and MemWe hold steady.
- StallM = (IDLE & acc) | (REQ & ~MemAck).
- While StallM=1, MEM/WB loads a bubble: RegWriteW=0 and ResultSrcW=0, all other MEM/WB fields hold. This prevents duplicate writebacks.
- MemAck is ignored outside REQ.
- Reset values, applied on any edge with rst=1, including mid-access:
  - state = IDLE.
  - MemReq, MemWe and MemErrM = 0.
  - MemAddr, MemWData and every MEM/WB output = 0.
  - An ack arriving after reset is ignored.

## Timing
- Non-memory instruction: 1 cycle through the stage, no stall.
- Memory access: minimum 2 cycles, consisting of the IDLE detect cycle plus one REQ cycle with an immediate ack. In general the access takes 1 + N cycles, where N is the number of cycles in REQ up to and including the ack.
- StallM falls combinationally in the ack cycle, so the next instruction enters on the following edge.
- Back-to-back accesses: the next access enters IDLE with acc=1 and stalls again. No REQ-to-REQ chaining.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments on each cycle in REQ without an ack.
  - When the counter reaches TIMEOUT-1 with no ack, the access is aborted: next state IDLE, MemReq=0, StallM=0 in that cycle, MemErrM=1 for one cycle.
  - On abort, MEM/WB loads with RegWriteW=0 and ReadDataW=0.
  - An ack in the same cycle as the timeout wins: the access completes normally and MemErrM stays 0.
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; MemErrM is constant 0.

## Test plan
- ALU op, RegWriteM=1, ALUResultM=0x0000_0042, RdM=5 -> after 1 edge RegWriteW=1, ALUResultW=0x42, RdW=5, StallM never asserted.
- Load from 0x0000_0103, MemAck on the first REQ cycle with MemRData=0xCAFE_F00D -> MemAddr=0x100, StallM=1 for exactly 1 cycle, then ReadDataW=0xCAFE_F00D, ResultSrcW=1.
- Store of 0x1234_5678 to 0x20 with ack delayed 3 cycles -> MemReq/MemWe/MemAddr/MemWData stable for 3 cycles, RegWriteW=0 throughout, a single ack completes the access, no duplicate request.
- rst asserted on the 2nd cycle of REQ, followed by a late ack -> MemReq=0 after the reset edge, state stays IDLE, MEM/WB outputs stay 0.
- MEM_TIMEOUT_EN with TIMEOUT=4, load never acked -> MemErrM pulses once after 4 REQ cycles, StallM drops, RegWriteW=0. Repeat with the ack in the 4th cycle -> normal completion, MemErrM=0.
